// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the complementary dead-time gate-drive stage.
//   dt_state_e   : one-hot per-channel drive state; the HS_ON and LS_ON bits
//                  are used directly as the high-side / low-side outputs.
//   CFG_EN_BIT   : config word bit holding the channel enable.
//   CFG_FCLR_BIT : config word bit requesting a fault-latch clear (not stored).
package pwm_deadtime_pkg;

  typedef enum logic [4:0] {
    OFF     = 5'b00001,
    DT_RISE = 5'b00010,
    HS_ON   = 5'b00100,
    DT_FALL = 5'b01000,
    LS_ON   = 5'b10000
  } dt_state_e;

  localparam int unsigned ST_HS_BIT    = 2;
  localparam int unsigned ST_LS_BIT    = 4;
  localparam int unsigned CFG_EN_BIT   = 16;
  localparam int unsigned CFG_FCLR_BIT = 17;

endpackage

// File: rtl/dt_channel.sv
// One complementary output pair with programmable dead time.
//   clk, rst   : system clock, asynchronous active-high reset
//   pwm_in     : raw PWM waveform for this channel
//   cfg_wen    : one-cycle write strobe for this channel's config register
//   w_data     : shared write data (dt in [DT_WIDTH-1:0], enable in bit 16)
//   force_off  : fault shutdown, drives the channel to OFF at the next edge
//   hs_out     : high-side drive (HS_ON state flop)
//   ls_out     : low-side drive (LS_ON state flop)
module dt_channel
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  input  logic        cfg_wen,
  input  logic [31:0] w_data,
  input  logic        force_off,
  output logic        hs_out,
  output logic        ls_out
);

  logic                r_pwm_q;
  logic                r_en;
  logic [DT_WIDTH-1:0] r_dt;
  logic [DT_WIDTH-1:0] r_cnt;
  dt_state_e           r_state;

  logic [DT_WIDTH-1:0] w_load;
  logic                w_dt_zero;
  logic                w_unused_bits;

  assign w_load        = r_dt - DT_WIDTH'(1);
  assign w_dt_zero     = (r_dt == '0);
  assign w_unused_bits = &{1'b0, w_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_q <= 1'b0;
      r_en    <= 1'b0;
      r_dt    <= '0;
      r_cnt   <= '0;
      r_state <= OFF;
    end else begin
      r_pwm_q <= pwm_in;
      if (cfg_wen) begin
        r_dt <= w_data[DT_WIDTH-1:0];
        r_en <= w_data[CFG_EN_BIT];
      end
      if (force_off || !r_en) begin
        r_state <= OFF;
      end else begin
        case (r_state)
          OFF: begin
            if (w_dt_zero) begin
              r_state <= r_pwm_q ? HS_ON : LS_ON;
            end else begin
              r_state <= r_pwm_q ? DT_RISE : DT_FALL;
              r_cnt   <= w_load;
            end
          end
          LS_ON: begin
            if (r_pwm_q) begin
              if (w_dt_zero) begin
                r_state <= HS_ON;
              end else begin
                r_state <= DT_RISE;
                r_cnt   <= w_load;
              end
            end
          end
          HS_ON: begin
            if (!r_pwm_q) begin
              if (w_dt_zero) begin
                r_state <= LS_ON;
              end else begin
                r_state <= DT_FALL;
                r_cnt   <= w_load;
              end
            end
          end
          // A pulse shorter than the band falls back to the side just released.
          DT_RISE: begin
            if (!r_pwm_q)          r_state <= LS_ON;
            else if (r_cnt == '0)  r_state <= HS_ON;
            else                   r_cnt   <= r_cnt - DT_WIDTH'(1);
          end
          DT_FALL: begin
            if (r_pwm_q)           r_state <= HS_ON;
            else if (r_cnt == '0)  r_state <= LS_ON;
            else                   r_cnt   <= r_cnt - DT_WIDTH'(1);
          end
          default: r_state <= OFF;
        endcase
      end
    end
  end

  assign hs_out = r_state[ST_HS_BIT];
  assign ls_out = r_state[ST_LS_BIT];

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead time and fault latch.
//   clk, rst      : system clock, asynchronous active-high reset
//   pwm_in        : raw PWM waveform per channel
//   cfg_wen       : per-channel config write strobe
//   w_data        : shared write data (dt, enable bit 16, fault-clear bit 17)
//   fault         : synchronous active-high shutdown request
//   hs_out/ls_out : high-side / low-side drive per channel
//   fault_latched : sticky fault status
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned DT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] pwm_in,
  input  logic [NUM_CHANNELS-1:0] cfg_wen,
  input  logic [31:0]             w_data,
  input  logic                    fault,
  output logic [NUM_CHANNELS-1:0] hs_out,
  output logic [NUM_CHANNELS-1:0] ls_out,
  output logic                    fault_latched
);

  logic r_fault_latched;
  logic w_force_off;
  logic w_clear;

  // Live fault is included so shutdown lands on the same edge that latches it.
  assign w_force_off = fault | r_fault_latched;
  assign w_clear     = (|cfg_wen) & w_data[CFG_FCLR_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_fault_latched <= 1'b0;
    else if (fault)   r_fault_latched <= 1'b1;
    else if (w_clear) r_fault_latched <= 1'b0;
  end

  assign fault_latched = r_fault_latched;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    dt_channel #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in[gi]),
      .cfg_wen   (cfg_wen[gi]),
      .w_data    (w_data),
      .force_off (w_force_off),
      .hs_out    (hs_out[gi]),
      .ls_out    (ls_out[gi])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pwm_in;
  logic [1:0]  cfg_wen;
  logic [31:0] w_data;
  logic        fault;
  logic [1:0]  hs_out;
  logic [1:0]  ls_out;
  logic        fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(
    .NUM_CHANNELS (2),
    .DT_WIDTH     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .cfg_wen       (cfg_wen),
    .w_data        (w_data),
    .fault         (fault),
    .hs_out        (hs_out),
    .ls_out        (ls_out),
    .fault_latched (fault_latched)
  );

  // Reference model: each channel is either off, or driving a side, possibly
  // still waiting out a gap of m_left more cycles before that side turns on.
  int m_pq[2], m_en[2], m_dt[2];
  int m_on[2], m_side[2], m_gapping[2], m_left[2];
  bit m_fl;
  logic [4:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pq[c] = 0; m_en[c] = 0; m_dt[c] = 0;
      m_on[c] = 0; m_side[c] = 0; m_gapping[c] = 0; m_left[c] = 0;
    end
    m_fl = 1'b0;
  endtask

  task automatic m_switch(input int c, input int want);
    m_on[c]   = 1;
    m_side[c] = want;
    if (m_dt[c] == 0) m_gapping[c] = 0;
    else begin
      m_gapping[c] = 1;
      m_left[c]    = m_dt[c] - 1;
    end
  endtask

  task automatic model_edge();
    logic [1:0] e_hs, e_ls;
    bit fo;
    if (rst) model_reset();
    else begin
      fo = fault || m_fl;
      for (int c = 0; c < 2; c++) begin
        if (fo || m_en[c] == 0) begin
          m_on[c] = 0; m_gapping[c] = 0;
        end else if (m_on[c] == 0) begin
          m_switch(c, m_pq[c]);
        end else if (m_gapping[c] != 0) begin
          if (m_pq[c] != m_side[c]) begin
            m_side[c] = m_pq[c]; m_gapping[c] = 0;
          end else if (m_left[c] == 0) m_gapping[c] = 0;
          else m_left[c] = m_left[c] - 1;
        end else if (m_pq[c] != m_side[c]) begin
          m_switch(c, m_pq[c]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        m_pq[c] = int'(pwm_in[c]);
        if (cfg_wen[c]) begin
          m_dt[c] = int'(w_data[7:0]);
          m_en[c] = int'(w_data[16]);
        end
      end
      if (fault) m_fl = 1'b1;
      else if (cfg_wen != 2'b00 && w_data[17]) m_fl = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      e_hs[c] = (m_on[c] != 0) && (m_gapping[c] == 0) && (m_side[c] == 1);
      e_ls[c] = (m_on[c] != 0) && (m_gapping[c] == 0) && (m_side[c] == 0);
    end
    exp_q.push_back({e_hs, e_ls, m_fl});
  endtask

  // Monitor: pops one expectation per cycle and checks the no-overlap rule.
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({hs_out, ls_out, fault_latched} !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got hs=%b ls=%b fl=%b expected hs=%b ls=%b fl=%b",
                 $time, hs_out, ls_out, fault_latched, e[4:3], e[2:1], e[0]);
      end
    end
    n_checks++;
    if ((hs_out & ls_out) !== 2'b00) begin
      n_fail++;
      $display("FAIL overlap t=%0t got hs&ls=%b expected 00", $time, hs_out & ls_out);
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cfg_wen = 2'b00;
  endtask

  task automatic set_cfg(input logic [1:0] mask, input int unsigned dt, input bit en, input bit clr);
    cfg_wen      = mask;
    w_data       = $urandom & 32'hFFFC_FF00;
    w_data[7:0]  = 8'(dt);
    w_data[16]   = en;
    w_data[17]   = clr;
  endtask

  task automatic wr(input logic [1:0] mask, input int unsigned dt, input bit en, input bit clr);
    set_cfg(mask, dt, en, clr);
    tick();
  endtask

  initial begin
    int hs_cnt, ls_cnt, gap_cnt, hs_seen, band_a, band_b;
    rst = 1'b1; pwm_in = 2'b00; cfg_wen = 2'b00; w_data = '0; fault = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_hs", int'(hs_out), 0);
    chk("reset_ls", int'(ls_out), 0);
    chk("reset_fl", int'(fault_latched), 0);
    rst = 1'b0;

    // Disabled channels stay dark while pwm toggles.
    for (int i = 0; i < 20; i++) begin
      pwm_in = 2'($urandom);
      tick();
    end

    // dt=5, 40/40 square on ch0.
    wr(2'b01, 5, 1'b1, 1'b0);
    hs_cnt = 0; ls_cnt = 0; gap_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      pwm_in[0] = ((i % 80) < 40);
      pwm_in[1] = 1'b0;
      tick();
      if (i >= 80 && i < 160) begin
        hs_cnt  += int'(hs_out[0]);
        ls_cnt  += int'(ls_out[0]);
        gap_cnt += int'(!hs_out[0] && !ls_out[0]);
      end
    end
    chk("dt5_hs_high", hs_cnt, 35);
    chk("dt5_ls_high", ls_cnt, 35);
    chk("dt5_gap", gap_cnt, 10);

    // dt=10, 3-cycle glitch from LS_ON.
    wr(2'b01, 10, 1'b1, 1'b0);
    pwm_in[0] = 1'b0;
    repeat (30) tick();
    hs_seen = 0; ls_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      pwm_in[0] = (i < 3);
      tick();
      hs_seen |= int'(hs_out[0]);
      ls_cnt  += int'(!ls_out[0]);
    end
    chk("glitch_hs_never", hs_seen, 0);
    chk("glitch_ls_low", ls_cnt, 3);

    // dt=0: direct switch, two cycles after the input edge.
    wr(2'b01, 0, 1'b1, 1'b0);
    pwm_in[0] = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 40; i++) begin
      pwm_in[0] = ((i % 10) < 5);
      tick();
      if (i == 0) chk("dt0_hs_early", int'(hs_out[0]), 0);
      if (i == 1) begin
        chk("dt0_hs_on", int'(hs_out[0]), 1);
        chk("dt0_ls_off", int'(ls_out[0]), 0);
      end
    end

    // Fault latch and clear.
    wr(2'b11, 4, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      pwm_in[0] = ((i % 16) < 8);
      pwm_in[1] = (((i + 5) % 16) < 8);
      tick();
    end
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chk("fault_fl", int'(fault_latched), 1);
    chk("fault_hs", int'(hs_out), 0);
    chk("fault_ls", int'(ls_out), 0);
    repeat (5) tick();
    fault = 1'b1;
    wr(2'b01, 4, 1'b1, 1'b1);
    chk("fault_clear_blocked", int'(fault_latched), 1);
    fault = 1'b0;
    repeat (3) tick();
    chk("fault_still_latched", int'(fault_latched), 1);
    wr(2'b10, 4, 1'b1, 1'b1);
    chk("fault_cleared", int'(fault_latched), 0);
    for (int i = 0; i < 30; i++) begin
      pwm_in[0] = ((i % 16) < 8);
      pwm_in[1] = (((i + 5) % 16) < 8);
      tick();
    end

    // dt change on ch1 while its band is running.
    wr(2'b10, 3, 1'b1, 1'b0);
    band_a = 0; band_b = 0;
    for (int i = 0; i < 100; i++) begin
      pwm_in[1] = ((i % 40) < 20);
      pwm_in[0] = ((i % 32) < 16);
      if (i == 42) set_cfg(2'b10, 8, 1'b1, 1'b0);
      tick();
      if (i >= 41 && i < 60) band_a += int'(!hs_out[1] && !ls_out[1]);
      if (i >= 60 && i < 80) band_b += int'(!hs_out[1] && !ls_out[1]);
    end
    chk("band_old_dt", band_a, 3);
    chk("band_new_dt", band_b, 8);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 7) == 0) pwm_in[c] = ~pwm_in[c];
      if ($urandom_range(0, 39) == 0)
        set_cfg(2'($urandom_range(1, 3)), $urandom_range(0, 7),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1));
      fault = ($urandom_range(0, 99) == 0);
      tick();
    end
    fault = 1'b0;

    // Asynchronous reset mid-operation.
    wr(2'b11, 2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      pwm_in = {((i % 6) < 3) ? 1'b1 : 1'b0, ((i % 8) < 4) ? 1'b1 : 1'b0};
      tick();
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    chk("async_rst_hs", int'(hs_out), 0);
    chk("async_rst_ls", int'(ls_out), 0);
    chk("async_rst_fl", int'(fault_latched), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
